spi_ram_slave: RTL and testbench

SPI_RAM_SLAVE -- requirements
Module: spi_ram_slave

---
 rtl/spi_ram_slave_pkg.sv | 22 ++
 rtl/spi_ram_mem.sv | 29 ++
 rtl/spi_ram_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_ram_slave.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_slave_pkg.sv
// Shared types and constants for the SPI-accessible RAM slave.
// Holds the FSM state type, the frame opcodes and the frame-length helper.
package spi_ram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    RESP
  } state_t;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  // Frame = 2-bit opcode followed by a payload wide enough for address or data.
  function automatic int unsigned frame_len(input int unsigned addr_w,
                                            input int unsigned data_w);
    return 2 + ((addr_w > data_w) ? addr_w : data_w);
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port-write / synchronous-read RAM used as the SPI slave's storage.
// Contents are intentionally not reset.
module spi_ram_mem
  import spi_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      dout <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_ram_slave.sv
// SPI slave giving serial access to an internal RAM: address/data frames in on
// MOSI, read data out on MISO, all synchronous to clk.
module spi_ram_slave
  import spi_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic rd_active
);

  localparam int unsigned F      = frame_len(ADDR_W, DATA_W);
  localparam int unsigned BCNT_W = $clog2(F);
  localparam int unsigned RCNT_W = $clog2(DATA_W + 1);

  state_t state, next_state;

  logic [BCNT_W-1:0] bit_cnt;
  logic [RCNT_W-1:0] rcnt;
  logic [F-2:0]      shreg;
  logic [F-1:0]      frame;
  logic [1:0]        opcode;
  logic              last_bit;
  logic              resp_done;

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_data;
  logic              mem_re;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] out_sh;

  // The frame currently completing: bits already shifted plus the one on MOSI now.
  assign frame     = {shreg, MOSI};
  assign opcode    = frame[F-1 -: 2];
  assign last_bit  = (bit_cnt == BCNT_W'(F - 1));
  assign resp_done = (rcnt == RCNT_W'(DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!SS_n) begin
          next_state = RECV;
        end
      end
      RECV: begin
        if (SS_n) begin
          next_state = IDLE;
        end else if (last_bit && (opcode == OP_RDATA)) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (SS_n) begin
          next_state = IDLE;
        end else if (resp_done) begin
          next_state = RECV;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // rcnt==0 is the RAM read cycle; rcnt 1..DATA_W present one bit each.
  // The MSB is taken straight from dout since out_sh cannot load it in time.
  always_comb begin
    MISO      = 1'b0;
    rd_active = 1'b0;
    mem_re    = 1'b0;
    if (state == RESP) begin
      mem_re    = (rcnt == '0);
      rd_active = (rcnt != '0);
      MISO      = rd_active & ((rcnt == RCNT_W'(1)) ? dout[DATA_W-1] : out_sh[DATA_W-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      rcnt    <= '0;
      shreg   <= '0;
      waddr   <= '0;
      raddr   <= '0;
      wr_pend <= 1'b0;
      wr_data <= '0;
      out_sh  <= '0;
    end else begin
      wr_pend <= 1'b0;
      // The write lands one cycle after decode, so waddr advances here too.
      if (wr_pend && AUTO_INC) begin
        waddr <= waddr + 1'b1;
      end
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          rcnt    <= '0;
        end
        RECV: begin
          if (!SS_n) begin
            shreg <= frame[F-2:0];
            rcnt  <= '0;
            if (last_bit) begin
              bit_cnt <= '0;
              case (opcode)
                OP_WADDR: waddr <= frame[ADDR_W-1:0];
                OP_WDATA: begin
                  wr_pend <= 1'b1;
                  wr_data <= frame[DATA_W-1:0];
                end
                OP_RADDR: raddr <= frame[ADDR_W-1:0];
                default: ;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= '0;
          end
        end
        RESP: begin
          if (!SS_n) begin
            if (rcnt == RCNT_W'(1)) begin
              out_sh <= dout << 1;
            end else begin
              out_sh <= out_sh << 1;
            end
            if (resp_done) begin
              rcnt    <= '0;
              bit_cnt <= '0;
              if (AUTO_INC) begin
                raddr <= raddr + 1'b1;
              end
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  spi_ram_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_pend),
    .waddr (waddr),
    .wdata (wr_data),
    .re    (mem_re),
    .raddr (raddr),
    .dout  (dout)
  );

endmodule

// File: tb/tb_spi_ram_slave.sv
// Directed bench for spi_ram_slave: default, no-auto-increment and 10-bit
// address instances driven by frame-level tasks with hand-computed results.
module tb_spi_ram_slave;
  import spi_ram_slave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss_n = 1'b1, mosi = 1'b0, miso, rd_active;
  logic ss_n_b = 1'b1, mosi_b = 1'b0, miso_b, rd_active_b;
  logic miso_c, rd_active_c;
  int checks = 0;
  int failures = 0;

  spi_ram_slave dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso), .rd_active(rd_active)
  );

  spi_ram_slave #(.AUTO_INC(1'b0)) dut_c (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_c), .rd_active(rd_active_c)
  );

  spi_ram_slave #(.ADDR_W(10), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b), .rd_active(rd_active_b)
  );

  always #5 clk = ~clk;

  task automatic set_pins(input bit b, input logic ss, input logic mo);
    if (b) begin
      ss_n_b = ss;
      mosi_b = mo;
    end else begin
      ss_n = ss;
      mosi = mo;
    end
  endtask

  task automatic select(input bit b);
    @(negedge clk);
    set_pins(b, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic deselect(input bit b);
    set_pins(b, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit b, input logic [1:0] op, input logic [9:0] pl);
    logic [11:0] fr;
    int f;
    f  = b ? 12 : 10;
    fr = b ? {op, pl} : {2'b00, op, pl[7:0]};
    for (int i = f - 1; i >= 0; i--) begin
      set_pins(b, 1'b0, fr[i]);
      @(negedge clk);
    end
    set_pins(b, 1'b0, 1'b0);
  endtask

  // Entered at the negedge right after the last bit of a read frame.
  task automatic read_word(input bit b, output logic [7:0] v, output bit timing_ok);
    timing_ok = ((b ? rd_active_b : rd_active) === 1'b0) && ((b ? miso_b : miso) === 1'b0);
    @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      if ((b ? rd_active_b : rd_active) !== 1'b1) timing_ok = 1'b0;
      v[i] = b ? miso_b : miso;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (miso !== 1'b0 || rd_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got miso=%b rd_active=%b expected 0 0", miso, rd_active);
    end
    checks++;
    if (dut.state !== IDLE || dut.waddr !== 8'h00 || dut.raddr !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got state=%0d waddr=%h raddr=%h expected 0 00 00",
               dut.state, dut.waddr, dut.raddr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] v;
    bit ok;
    select(0);
    send_frame(0, OP_WADDR, 10'h03A);
    send_frame(0, OP_WDATA, 10'h05C);
    send_frame(0, OP_RADDR, 10'h03A);
    send_frame(0, OP_RDATA, 10'h000);
    read_word(0, v, ok);
    checks++;
    if (v !== 8'h5C) begin
      failures++;
      $display("FAIL basic_read: got %h expected 5c", v);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL basic_timing: got %b expected 1", ok);
    end
    deselect(0);
    checks++;
    if (dut.state !== IDLE || miso !== 1'b0 || rd_active !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: got state=%0d miso=%b rd_active=%b expected 0 0 0",
               dut.state, miso, rd_active);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v1, v2;
    bit ok1, ok2;
    select(0);
    send_frame(0, OP_WADDR, 10'h010);
    send_frame(0, OP_WDATA, 10'h0AA);
    send_frame(0, OP_WDATA, 10'h0BB);
    send_frame(0, OP_RADDR, 10'h010);
    send_frame(0, OP_RDATA, 10'h000);
    read_word(0, v1, ok1);
    send_frame(0, OP_RDATA, 10'h3FF);
    read_word(0, v2, ok2);
    deselect(0);
    checks++;
    if (v1 !== 8'hAA || v2 !== 8'hBB) begin
      failures++;
      $display("FAIL autoinc_reads: got %h %h expected aa bb", v1, v2);
    end
    checks++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1) begin
      failures++;
      $display("FAIL autoinc_timing: got %b %b expected 1 1", ok1, ok2);
    end
    checks++;
    if (dut.waddr !== 8'h12 || dut.raddr !== 8'h12) begin
      failures++;
      $display("FAIL autoinc_addr: got waddr=%h raddr=%h expected 12 12", dut.waddr, dut.raddr);
    end
    checks++;
    if (dut_c.u_mem.mem[16] !== 8'hBB || dut_c.waddr !== 8'h10 || dut_c.raddr !== 8'h10) begin
      failures++;
      $display("FAIL hold_addr: got mem=%h waddr=%h raddr=%h expected bb 10 10",
               dut_c.u_mem.mem[16], dut_c.waddr, dut_c.raddr);
    end
  endtask

  task automatic test_wrap;
    select(0);
    send_frame(0, OP_WADDR, 10'h0FF);
    send_frame(0, OP_WDATA, 10'h011);
    send_frame(0, OP_WDATA, 10'h022);
    deselect(0);
    checks++;
    if (dut.u_mem.mem[255] !== 8'h11 || dut.u_mem.mem[0] !== 8'h22) begin
      failures++;
      $display("FAIL wrap_mem: got %h %h expected 11 22", dut.u_mem.mem[255], dut.u_mem.mem[0]);
    end
    checks++;
    if (dut.waddr !== 8'h01) begin
      failures++;
      $display("FAIL wrap_waddr: got %h expected 01", dut.waddr);
    end
  endtask

  task automatic test_abort;
    logic [9:0] fr;
    select(0);
    send_frame(0, OP_WADDR, 10'h041);
    send_frame(0, OP_WDATA, 10'h066);
    send_frame(0, OP_WADDR, 10'h041);
    deselect(0);
    select(0);
    fr = {OP_WDATA, 8'h77};
    for (int i = 9; i >= 4; i--) begin
      set_pins(0, 1'b0, fr[i]);
      @(negedge clk);
    end
    deselect(0);
    checks++;
    if (dut.u_mem.mem[65] !== 8'h66 || dut.waddr !== 8'h41) begin
      failures++;
      $display("FAIL abort_nowrite: got mem=%h waddr=%h expected 66 41", dut.u_mem.mem[65], dut.waddr);
    end
    select(0);
    send_frame(0, OP_WDATA, 10'h055);
    deselect(0);
    checks++;
    if (dut.u_mem.mem[65] !== 8'h55 || dut.waddr !== 8'h42) begin
      failures++;
      $display("FAIL abort_recover: got mem=%h waddr=%h expected 55 42", dut.u_mem.mem[65], dut.waddr);
    end
  endtask

  task automatic test_reset_resp;
    select(0);
    send_frame(0, OP_RADDR, 10'h010);
    send_frame(0, OP_RDATA, 10'h000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (miso !== 1'b1 || rd_active !== 1'b1) begin
      failures++;
      $display("FAIL resp_bit3: got miso=%b rd_active=%b expected 1 1", miso, rd_active);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (miso !== 1'b0 || rd_active !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: got miso=%b rd_active=%b expected 0 0", miso, rd_active);
    end
    set_pins(0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state !== IDLE || dut.waddr !== 8'h00 || dut.raddr !== 8'h00) begin
      failures++;
      $display("FAIL rst_after: got state=%0d waddr=%h raddr=%h expected 0 00 00",
               dut.state, dut.waddr, dut.raddr);
    end
    checks++;
    if (dut.u_mem.mem[16] !== 8'hAA) begin
      failures++;
      $display("FAIL ram_kept: got %h expected aa", dut.u_mem.mem[16]);
    end
  endtask

  task automatic test_wide;
    logic [7:0] v;
    bit ok;
    select(1);
    send_frame(1, OP_WADDR, 10'h3FF);
    send_frame(1, OP_WDATA, 10'h0A5);
    send_frame(1, OP_RADDR, 10'h3FF);
    send_frame(1, OP_RDATA, 10'h000);
    read_word(1, v, ok);
    deselect(1);
    checks++;
    if (dut_b.u_mem.mem[1023] !== 8'hA5) begin
      failures++;
      $display("FAIL wide_mem: got %h expected a5", dut_b.u_mem.mem[1023]);
    end
    checks++;
    if (v !== 8'hA5 || ok !== 1'b1) begin
      failures++;
      $display("FAIL wide_read: got %h timing=%b expected a5 1", v, ok);
    end
    checks++;
    if (dut_b.waddr !== 10'h000 || dut_b.raddr !== 10'h000) begin
      failures++;
      $display("FAIL wide_wrap: got waddr=%h raddr=%h expected 000 000", dut_b.waddr, dut_b.raddr);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_wrap;
    test_abort;
    test_reset_resp;
    test_wide;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
